apb_reg_bridge: RTL and testbench
=================================

APB_REG_BRIDGE -- requirements
Module: apb_reg_bridge

Interface
REQ-001 Parameter ADDR_W, default 26, SHALL set the width of paddr and reg_addr.
REQ-002 Parameter TIMEOUT, default 16, range 1..255, SHALL set the maximum number of cycles to wait for reg_ack before an error response.
REQ-003 The block SHALL use one clock and an asynchronous active-low reset, with the ports named clk and rst_n.
REQ-004 Ports (name, direction, width, meaning):
  clk  in  1  clock
  rst_n  in  1  async active-low reset
  psel  in  1  APB select
  penable  in  1  APB access phase
  pready  out  1  APB ready
  paddr  in  ADDR_W  APB address
  pwrite  in  1  APB write
  pwdata  in  32  APB write data
  pwstrb  in  4  APB byte strobes
  prdata  out  32  APB read data
  pslverr  out  1  APB error
  reg_addr  out  ADDR_W  captured address
  reg_read  out  1  read request pulse
  reg_write  out  1  write request pulse
  reg_wdata  out  32  captured write data
  reg_wstrb  out  4  write byte enables
  reg_rdata  in  32  read data, valid when reg_ack is high
  reg_ack  in  1  target completion
  reg_err  in  1  target error, valid when reg_ack is high

Function
REQ-005 The FSM SHALL have four states: IDLE, REQ, WAIT and RESP.
REQ-006 IDLE: when psel and penable are both high, the block SHALL latch paddr, pwrite, pwdata and pwstrb into reg_addr, reg_wdata, reg_wstrb and an internal write flag, then evaluate the access error.
REQ-007 An access error SHALL be either of these:
  - paddr[1:0] is non-zero.
  - A write with pwstrb other than 4'hF (build without the macro of REQ-020).
REQ-008 On an access error, IDLE SHALL go to RESP with the error flag set, and SHALL NOT pulse reg_read or reg_write.
REQ-009 Without an access error, IDLE SHALL go to REQ.
REQ-010 In REQ, exactly one of reg_read or reg_write SHALL be high, for exactly one cycle.
REQ-011 Transitions out of REQ:
  - reg_ack high in REQ: go to RESP.
  - Otherwise: go to WAIT.
REQ-012 In REQ and WAIT, a timeout counter SHALL increment every cycle.
REQ-013 Transitions out of WAIT:
  - reg_ack high: go to RESP.
  - Counter reaches TIMEOUT with reg_ack low: go to RESP with the error flag set.
  - reg_ack and timeout in the same cycle: reg_ack SHALL win.
REQ-014 On reg_ack for a read, reg_rdata SHALL be registered into prdata, and reg_err SHALL be registered as the error flag.
REQ-015 RESP behaviour:
  - pready SHALL be high for exactly one cycle, and SHALL be low in all other states.
  - pslverr SHALL equal the error flag.
  - prdata SHALL hold the captured data for a successful read, and 0 otherwise.
  - The next state SHALL be IDLE.
REQ-016 pslverr and prdata SHALL be 0 whenever pready is low.
REQ-017 Latency:
  - Error-free transfer with reg_ack in the REQ cycle: pready rises 2 cycles after the first access-phase cycle.
  - Access error: pready rises 1 cycle after the first access-phase cycle.
REQ-018 Stray inputs:
  - reg_ack asserted in IDLE or RESP SHALL be ignored.
  - Deassertion of psel mid-transfer SHALL NOT abort the FSM; the transfer SHALL complete through RESP.
REQ-019 The IDLE-to-IDLE back-to-back limit SHALL be one new access phase accepted per RESP-to-IDLE return; no acceptance SHALL occur in RESP.

Configuration
REQ-020 With macro APB_REG_BRIDGE_PSTRB_EN defined:
  - Partial writes SHALL be legal, and reg_wstrb SHALL equal the latched pwstrb.
  - A write with pwstrb equal to 4'h0 SHALL be an access error.
  - For reads, reg_wstrb SHALL be 4'h0.
REQ-021 Without APB_REG_BRIDGE_PSTRB_EN:
  - Any write with pwstrb other than 4'hF SHALL be an access error.
  - reg_wstrb SHALL be 4'hF for writes and 4'h0 for reads.

Reset
REQ-022 While rst_n is low, the following SHALL be held:
  - FSM in IDLE.
  - Timeout counter at 0.
  - Error flag at 0.
  - pready, pslverr, reg_read and reg_write at 0.
  - prdata, reg_addr, reg_wdata and reg_wstrb at 0.
REQ-023 Reset asserted in any state SHALL abort the transfer immediately, with no pready or request pulse afterwards; the block SHALL resume in IDLE on the first clock edge after rst_n rises.

Verification
REQ-024 Write: paddr=0x000004, pwdata=0xDEADBEEF, pwstrb=F, reg_ack in the REQ cycle -> one reg_write pulse with reg_wdata=0xDEADBEEF, pready 2 cycles after the access phase starts, pslverr=0.
REQ-025 Read: paddr=0x200000, reg_ack 3 cycles after reg_read, reg_rdata=0x00000007 -> prdata=0x7 with pready, pslverr=0, prdata=0 in the following cycle.
REQ-026 Unaligned read: paddr=0x000002 -> no reg_read pulse, pready 1 cycle after the access phase starts, pslverr=1, prdata=0.
REQ-027 Timeout: TIMEOUT=4, reg_ack held low -> pready with pslverr=1 exactly 4 cycles after REQ; a later reg_ack is ignored.
REQ-028 Partial write: pwstrb=4'h3 -> with APB_REG_BRIDGE_PSTRB_EN, reg_write pulses with reg_wstrb=3; without the macro, pslverr=1 and no reg_write pulse.
REQ-029 Reset mid-operation: rst_n pulsed low during WAIT -> all outputs 0, no pready pulse; a subsequent read completes normally.

Source files
------------

// File: rtl/apb_reg_bridge.sv
// APB slave to simple register-port bridge with ack timeout and access-error checks.
// Define APB_REG_BRIDGE_PSTRB_EN to allow partial-strobe writes (otherwise only 4'hF writes are legal).
module apb_reg_bridge #(
  parameter int ADDR_W  = 26,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  output logic              pready,
  input  logic [ADDR_W-1:0] paddr,
  input  logic              pwrite,
  input  logic [31:0]       pwdata,
  input  logic [3:0]        pwstrb,
  output logic [31:0]       prdata,
  output logic              pslverr,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_read,
  output logic              reg_write,
  output logic [31:0]       reg_wdata,
  output logic [3:0]        reg_wstrb,
  input  logic [31:0]       reg_rdata,
  input  logic              reg_ack,
  input  logic              reg_err
);

  // state | meaning
  // IDLE  | waiting for an APB access phase
  // REQ   | one-cycle reg_read / reg_write pulse
  // WAIT  | waiting for reg_ack or timeout
  // RESP  | pready for one cycle with pslverr / prdata
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  localparam logic [8:0] TMO_LIM = 9'(TIMEOUT);

  state_t      state, state_nxt;
  logic [7:0]  tmo_cnt;
  logic        wr_flag;
  logic        err_flag;
  logic [31:0] rdata_q;
  logic        access;
  logic        strb_err;
  logic        acc_err;
  logic        tmo_hit;
  logic [3:0]  wstrb_lat;

  assign access = psel & penable;

`ifdef APB_REG_BRIDGE_PSTRB_EN
  assign strb_err  = pwrite & (pwstrb == 4'h0);
  assign wstrb_lat = pwrite ? pwstrb : 4'h0;
`else
  assign strb_err  = pwrite & (pwstrb != 4'hF);
  assign wstrb_lat = pwrite ? 4'hF : 4'h0;
`endif

  assign acc_err = (paddr[1:0] != 2'b00) | strb_err;
  // Counter value after this cycle's increment has reached the limit.
  assign tmo_hit = ({1'b0, tmo_cnt} + 9'd1) >= TMO_LIM;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pready    = 1'b0;
    pslverr   = 1'b0;
    prdata    = '0;
    reg_read  = 1'b0;
    reg_write = 1'b0;
    case (state)
      IDLE: if (access) state_nxt = acc_err ? RESP : REQ;
      REQ: begin
        reg_write = wr_flag;
        reg_read  = ~wr_flag;
        state_nxt = reg_ack ? RESP : WAIT;
      end
      WAIT: if (reg_ack || tmo_hit) state_nxt = RESP;
      RESP: begin
        pready    = 1'b1;
        pslverr   = err_flag;
        prdata    = (wr_flag || err_flag) ? 32'h0 : rdata_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt   <= '0;
      wr_flag   <= 1'b0;
      err_flag  <= 1'b0;
      rdata_q   <= '0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wstrb <= '0;
    end else begin
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (access) begin
            reg_addr  <= paddr;
            reg_wdata <= pwdata;
            reg_wstrb <= wstrb_lat;
            wr_flag   <= pwrite;
            err_flag  <= acc_err;
          end
        end
        REQ, WAIT: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          // A same-cycle ack takes priority over the timeout.
          if (reg_ack) begin
            err_flag <= reg_err;
            if (!wr_flag) rdata_q <= reg_rdata;
          end else if (state == WAIT && tmo_hit) begin
            err_flag <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_reg_bridge.sv
// Scoreboard bench for apb_reg_bridge: expected requests/responses queued at drive time, popped by a monitor.
`timescale 1ns/1ps
module tb_apb_reg_bridge;
  localparam int ADDR_W  = 26;
  localparam int TIMEOUT = 4;
`ifdef APB_REG_BRIDGE_PSTRB_EN
  localparam bit PSTRB_EN = 1'b1;
`else
  localparam bit PSTRB_EN = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              psel, penable, pready, pwrite, pslverr;
  logic [ADDR_W-1:0] paddr, reg_addr;
  logic [31:0]       pwdata, prdata, reg_wdata, reg_rdata;
  logic [3:0]        pwstrb, reg_wstrb;
  logic              reg_read, reg_write, reg_ack, reg_err;

  apb_reg_bridge #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pready(pready),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pwstrb(pwstrb),
    .prdata(prdata), .pslverr(pslverr), .reg_addr(reg_addr), .reg_read(reg_read),
    .reg_write(reg_write), .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb),
    .reg_rdata(reg_rdata), .reg_ack(reg_ack), .reg_err(reg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] prdata;
    logic        slverr;
    int          lat;
    int          start;
  } resp_t;

  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
  } req_t;

  resp_t resp_q[$];
  req_t  req_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin : mon
    req_t  r;
    resp_t e;
    if (!rst_n) begin
      chk("rst_ctrl", {28'h0, pready, pslverr, reg_read, reg_write}, 32'h0);
      chk("rst_prdata", prdata, 32'h0);
      chk("rst_addr", 32'(reg_addr), 32'h0);
      chk("rst_wdata", reg_wdata, 32'h0);
      chk("rst_wstrb", 32'(reg_wstrb), 32'h0);
    end else begin
      chk("rd_wr_excl", 32'(reg_read & reg_write), 32'h0);
      if (reg_read | reg_write) begin
        chk("req_pending", 32'(req_q.size() != 0), 32'h1);
        if (req_q.size() != 0) begin
          r = req_q.pop_front();
          chk("req_is_write", 32'(reg_write), 32'(r.wr));
          chk("reg_addr", 32'(reg_addr), 32'(r.addr));
          if (r.wr) chk("reg_wdata", reg_wdata, r.wdata);
          chk("reg_wstrb", 32'(reg_wstrb), 32'(r.wstrb));
        end
      end
      if (pready) begin
        chk("resp_pending", 32'(resp_q.size() != 0), 32'h1);
        if (resp_q.size() != 0) begin
          e = resp_q.pop_front();
          chk("prdata", prdata, e.prdata);
          chk("pslverr", 32'(pslverr), 32'(e.slverr));
          chk("latency", 32'(cyc - e.start), 32'(e.lat));
        end
      end else begin
        chk("prdata_idle", prdata, 32'h0);
        chk("pslverr_idle", 32'(pslverr), 32'h0);
      end
    end
  end

  // ack_dly: cycles after the reg_read/reg_write cycle to assert reg_ack (0 = same cycle, <0 = never)
  task automatic apb_xfer(input logic [ADDR_W-1:0] addr, input logic wr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int ack_dly, input logic [31:0] rdata,
                          input logic rerr, input bit drop_early);
    resp_t e;
    req_t  r;
    bit    aerr, acked, seen, done;
    int    k;
    aerr  = (addr[1:0] != 2'b00) || (wr && (PSTRB_EN ? (strb == 4'h0) : (strb != 4'hF)));
    acked = !aerr && ack_dly >= 0 && ack_dly <= TIMEOUT - 1;
    if (!aerr) begin
      r.wr    = wr;
      r.addr  = addr;
      r.wdata = wdata;
      r.wstrb = wr ? (PSTRB_EN ? strb : 4'hF) : 4'h0;
      req_q.push_back(r);
    end
    e.slverr = aerr ? 1'b1 : (acked ? rerr : 1'b1);
    e.prdata = (acked && !wr && !rerr) ? rdata : 32'h0;
    e.lat    = aerr ? 1 : (acked ? 2 + ack_dly : TIMEOUT + 1);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wdata; pwstrb = strb;
    @(negedge clk);
    penable = 1'b1;
    e.start = cyc;
    resp_q.push_back(e);
    seen = 0; done = 0; k = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      reg_ack   = 1'b0;
      reg_rdata = $urandom();
      reg_err   = 1'($urandom_range(0, 1));
      if (reg_read | reg_write) begin
        seen = 1;
        k = 0;
      end
      if (seen) begin
        if (k == ack_dly) begin
          reg_ack = 1'b1; reg_rdata = rdata; reg_err = rerr;
        end
        k++;
      end
      if (drop_early && i == 0) begin
        psel = 1'b0; penable = 1'b0;
      end
      if (pready) done = 1;
    end
    chk("xfer_done", 32'(done), 32'h1);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; reg_ack = 1'b0;
    chk("req_q_empty", 32'(req_q.size()), 32'h0);
    chk("resp_q_empty", 32'(resp_q.size()), 32'h0);
  endtask

  task automatic stray_ack(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reg_ack = 1'b1; reg_err = 1'b1; reg_rdata = 32'hBAD0_BAD0;
    end
    @(negedge clk);
    reg_ack = 1'b0;
  endtask

  initial begin
    logic [ADDR_W-1:0] a;
    logic [3:0]        s;
    req_t              r;
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; paddr = '0; pwrite = 1'b0;
    pwdata = '0; pwstrb = '0; reg_rdata = '0; reg_ack = 1'b0; reg_err = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    apb_xfer(26'h000004, 1'b1, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0, 1'b0);
    apb_xfer(26'h200000, 1'b0, 32'h0, 4'h0, 3, 32'h00000007, 1'b0, 1'b0);
    apb_xfer(26'h000002, 1'b0, 32'h0, 4'h0, 0, 32'h12345678, 1'b0, 1'b0);
    apb_xfer(26'h000010, 1'b0, 32'h0, 4'h0, -1, 32'h0, 1'b0, 1'b0);
    stray_ack(2);
    apb_xfer(26'h000008, 1'b1, 32'hCAFEF00D, 4'h3, 0, 32'h0, 1'b0, 1'b0);
    apb_xfer(26'h00000C, 1'b1, 32'h0BADCAFE, 4'h0, 0, 32'h0, 1'b0, 1'b0);
    apb_xfer(26'h000020, 1'b0, 32'h0, 4'h0, 1, 32'hA5A5A5A5, 1'b1, 1'b0);
    apb_xfer(26'h000024, 1'b0, 32'h0, 4'h0, 2, 32'h13579BDF, 1'b0, 1'b1);
    apb_xfer(26'h000028, 1'b1, 32'h11223344, 4'hF, 3, 32'h0, 1'b1, 1'b0);

    // Reset during WAIT: the read pulse is expected, the response is not.
    r.wr = 1'b0; r.addr = 26'h000030; r.wdata = 32'h0; r.wstrb = 4'h0;
    req_q.push_back(r);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; paddr = 26'h000030; pwrite = 1'b0; pwstrb = 4'h0;
    @(negedge clk);
    penable = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    psel = 1'b0; penable = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("rst_req_q_empty", 32'(req_q.size()), 32'h0);
    apb_xfer(26'h000034, 1'b0, 32'h0, 4'h0, 1, 32'h0000BEEF, 1'b0, 1'b0);

    for (int t = 0; t < 10; t++) begin
      a = ADDR_W'($urandom());
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      case ($urandom_range(0, 2))
        0:       s = 4'hF;
        1:       s = 4'h0;
        default: s = 4'($urandom_range(1, 14));
      endcase
      apb_xfer(a, 1'($urandom_range(0, 1)), $urandom(), s, $urandom_range(0, 5),
               $urandom(), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge clk);
    chk("final_req_q", 32'(req_q.size()), 32'h0);
    chk("final_resp_q", 32'(resp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
